lane_sprite_reader: RTL
=======================

Name: lane_sprite_reader

Overview:
- Reads the 72x32 lane block ROM (8-bit address, 32-bit row, combinational read). Four 18-row sprites: empty at base 0, unpressed at 18, pressed at 36, note at 54.
- Turns the VGA scan position and the per-lane sprite selection into a single foreground bit per pixel, for a row of N_LANES fret sprites.
- Sits between the VGA controller (DrawX/DrawY plus pixel enable) and the color mapper.
- Two-stage pipeline: stage 1 computes and registers the ROM address; stage 2 samples the ROM row and selects the bit.

Parameters:
- N_LANES, 5: number of lane sprites drawn left to right.
- LANE_X0, 160: x of column 0 of lane 0.
- LANE_PITCH, 64: x distance between lane origins. Must be a power of 2 and ≥ SPRITE_W.
- LANE_Y0, 400: y of row 0 of every sprite.
- SPRITE_W, 32: sprite width. Equals the ROM data width.
- SPRITE_H, 18: sprite height in rows. Also the ROM stride between sprites.

Ports:
- Clk, in, 1: system clock.
- Reset_n, in, 1: asynchronous, active-low reset.
- pix_en, in, 1: pixel strobe. The pipeline advances only on Clk edges where pix_en=1.
- DrawX, in, 10: current scan x.
- DrawY, in, 10: current scan y.
- lane_state, in, 2*N_LANES: 2 bits per lane; lane i is at [2i+1:2i]. 0=empty, 1=unpressed, 2=pressed, 3=note.
- rom_addr, out, 8: registered ROM address.
- rom_data, in, 32: ROM row for rom_addr, combinational.
- pixel_on, out, 1: sprite foreground bit.
- pixel_lane, out, $clog2(N_LANES): lane index of the pixel.
- pixel_valid, out, 1: pipeline holds a real sample.

Behaviour:
- Reset (async, Reset_n=0): rom_addr=0, pixel_on=0, pixel_lane=0, pixel_valid=0. All stage-1 registers (s1_hit, s1_col, s1_lane, s1_valid) are 0. Reset mid-frame discards in-flight samples.
- Hit decode (combinational, from DrawX/DrawY):
  - x_rel = DrawX - LANE_X0, 10-bit.
  - lane = x_rel / LANE_PITCH (shift).
  - col = x_rel % LANE_PITCH (mask).
  - row = DrawY - LANE_Y0.
  - hit = (DrawX ≥ LANE_X0) & (lane < N_LANES) & (col < SPRITE_W) & (DrawY ≥ LANE_Y0) & (row < SPRITE_H).
  - Comparisons are unsigned, so no wrap-around false hits.
- Stage 1, on Clk with pix_en=1:
  - rom_addr ← hit ? lane_state[lane]*SPRITE_H + row : 0. Arithmetic is 8 bits; the maximum is 3*18+17=71.
  - s1_hit ← hit; s1_col ← col[4:0]; s1_lane ← hit ? lane : 0; s1_valid ← 1.
  - lane_state is sampled only here. A state change therefore takes effect on the next strobed pixel, never mid-pipeline.
- Stage 2, on Clk with pix_en=1:
  - pixel_on ← s1_hit & rom_data[SPRITE_W-1 - s1_col]. Column 0 is the MSB (bit 31).
  - pixel_lane ← s1_lane; pixel_valid ← s1_valid.
- Latency: outputs correspond to the DrawX/DrawY presented at the pix_en strobe two strobes earlier.
  - pixel_valid first goes 1 on the second strobe after reset.
  - pixel_valid stays 1 until the next reset.
- pix_en=0: every register holds, so outputs freeze.
- Non-hit pixels: rom_addr=0, which is the empty sprite; pixel_on is forced 0 by s1_hit regardless.
- An empty lane (state 0) always yields pixel_on=0, but pixel_lane still reports the lane.
- No combinational path from any input to any output.

Test Plan:
- Reset, then two pix_en strobes at DrawX=0, DrawY=0:
  - pixel_valid=0 after the first strobe and 1 after the second.
  - rom_addr=0, pixel_on=0.
- Lane 0 state=1 (unpressed), DrawY=401:
  - DrawX=162: rom_addr=19, two strobes later pixel_on=1, pixel_lane=0.
  - DrawX=161: pixel_on=0.
- Lane 2 state=2 (pressed), DrawY=404:
  - DrawX=288: rom_addr=40, pixel_on=1.
  - DrawX=293: pixel_on=0.
- Lane 4 state=3 (note), DrawX=420, DrawY=408: rom_addr=62, pixel_on=1, pixel_lane=4.
- Misses all produce rom_addr=0 and pixel_on=0:
  - DrawX=192 (col 32, the gap).
  - DrawX=480 (lane 5).
  - DrawX=100 (left of LANE_X0).
  - DrawY=418 (row 18).
- Hold pix_en=0 for 10 cycles while DrawX changes: all outputs unchanged. Assert Reset_n=0 mid-stream: outputs go to 0 immediately, without waiting for Clk.

Source files
------------

// File: rtl/lane_sprite_reader.sv
// Maps the VGA scan position onto a row of fret sprites and produces one foreground bit per pixel.
// Stage 1 registers the sprite ROM address; stage 2 picks the column bit out of the returned row.
module lane_sprite_reader #(
    parameter int N_LANES    = 5,
    parameter int LANE_X0    = 160,
    parameter int LANE_PITCH = 64,
    parameter int LANE_Y0    = 400,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 18,
    localparam int LANE_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   pix_en,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [2*N_LANES-1:0]   lane_state,
    output logic [7:0]             rom_addr,
    input  logic [SPRITE_W-1:0]    rom_data,
    output logic                   pixel_on,
    output logic [LANE_W-1:0]      pixel_lane,
    output logic                   pixel_valid
);

    localparam int LANE_SHIFT = $clog2(LANE_PITCH);
    localparam int COL_W      = $clog2(SPRITE_W);

    logic [9:0]        w_xRel;
    logic [9:0]        w_laneIdx;
    logic [9:0]        w_col;
    logic [9:0]        w_row;
    logic              w_hit;
    logic [1:0]        w_laneState;
    logic [7:0]        w_addrNext;
    logic [COL_W-1:0]  w_bitSel;

    logic [7:0]        r_romAddr;
    logic              r_s1Hit;
    logic [COL_W-1:0]  r_s1Col;
    logic [LANE_W-1:0] r_s1Lane;
    logic              r_s1Valid;
    logic              r_pixelOn;
    logic [LANE_W-1:0] r_pixelLane;
    logic              r_pixelValid;

    assign w_xRel    = DrawX - 10'(LANE_X0);
    assign w_laneIdx = w_xRel >> LANE_SHIFT;
    assign w_col     = w_xRel & 10'(LANE_PITCH - 1);
    assign w_row     = DrawY - 10'(LANE_Y0);

    // The explicit >= checks stop the unsigned subtractions above from wrapping into false hits.
    assign w_hit = (DrawX >= 10'(LANE_X0)) && (w_laneIdx < 10'(N_LANES)) &&
                   (w_col < 10'(SPRITE_W)) && (DrawY >= 10'(LANE_Y0)) &&
                   (w_row < 10'(SPRITE_H));

    always_comb begin
        w_laneState = 2'd0;
        for (int i = 0; i < N_LANES; i++) begin
            if (w_laneIdx == 10'(i)) begin
                w_laneState = lane_state[2*i +: 2];
            end
        end
    end

    assign w_addrNext = w_hit ? (8'(w_laneState) * 8'(SPRITE_H) + 8'(w_row)) : 8'd0;

    // Column 0 of a sprite lives in the MSB of the ROM row.
    assign w_bitSel = COL_W'(SPRITE_W - 1) - r_s1Col;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_romAddr    <= 8'd0;
            r_s1Hit      <= 1'b0;
            r_s1Col      <= '0;
            r_s1Lane     <= '0;
            r_s1Valid    <= 1'b0;
            r_pixelOn    <= 1'b0;
            r_pixelLane  <= '0;
            r_pixelValid <= 1'b0;
        end else if (pix_en) begin
            r_romAddr    <= w_addrNext;
            r_s1Hit      <= w_hit;
            r_s1Col      <= w_col[COL_W-1:0];
            r_s1Lane     <= w_hit ? w_laneIdx[LANE_W-1:0] : '0;
            r_s1Valid    <= 1'b1;
            r_pixelOn    <= r_s1Hit & rom_data[w_bitSel];
            r_pixelLane  <= r_s1Lane;
            r_pixelValid <= r_s1Valid;
        end
    end

    assign rom_addr    = r_romAddr;
    assign pixel_on    = r_pixelOn;
    assign pixel_lane  = r_pixelLane;
    assign pixel_valid = r_pixelValid;

endmodule
